rggen_bus_initiator: RTL and testbench
======================================

# rggen_bus_initiator

Initiator-side engine for the rggen common register bus: it drives `valid/access/address/write_data/strobe` into a bus adapter and consumes `ready/status/read_data` from it. Commands arrive on a valid/ready command port. Each command is issued as exactly one bus transaction. The result is returned on a valid/ready response port, with an optional timeout guard. It sits between a host-side agent (debug bridge, sequencer, CPU shim) and the register block's bus adapter.

## Interface
- ADDRESS_WIDTH, 8, bus address width
- BUS_WIDTH, 32, data width
- STROBE_WIDTH, BUS_WIDTH/8, byte-strobe width
- TIMEOUT_CYCLES, 0, maximum cycles `o_bus_valid` stays high waiting for ready; 0 disables the timeout
- i_clk  input  1  clock
- i_rst_n  input  1  reset; asynchronous, active-low
- i_cmd_valid  input  1  command offered
- o_cmd_ready  output  1  command accepted when high with `i_cmd_valid`
- i_cmd_access  input  2  access code, passed through unchanged
- i_cmd_address  input  ADDRESS_WIDTH  command address
- i_cmd_write_data  input  BUS_WIDTH  write data
- i_cmd_strobe  input  STROBE_WIDTH  byte strobes
- o_bus_valid  output  1  bus request
- o_bus_access  output  2  registered access code
- o_bus_address  output  ADDRESS_WIDTH  registered address
- o_bus_write_data  output  BUS_WIDTH  registered write data
- o_bus_strobe  output  STROBE_WIDTH  registered strobes
- i_bus_ready  input  1  transaction complete
- i_bus_status  input  2  completion status
- i_bus_read_data  input  BUS_WIDTH  read data
- o_rsp_valid  output  1  response available
- i_rsp_ready  input  1  response consumed
- o_rsp_status  output  2  captured status
- o_rsp_read_data  output  BUS_WIDTH  captured read data
- o_rsp_timeout  output  1  response produced by timeout
- o_busy  output  1  state != IDLE

## Operation
- **States:** IDLE, BUS, RESP. Reset enters IDLE.
- **IDLE**
  - `o_cmd_ready=1`.
  - On `i_cmd_valid`: register access, address, write_data and strobe into the bus payload registers, clear the timeout counter, go to BUS.
- **BUS**
  - `o_bus_valid=1`. Payload is held stable until the state is left.
  - On `i_bus_ready`:
    - capture `i_bus_status` into `o_rsp_status`;
    - capture `i_bus_read_data` into `o_rsp_read_data` if access == `RGGEN_READ`, else load 0;
    - clear `o_rsp_timeout`; go to RESP.
  - Otherwise, with TIMEOUT_CYCLES != 0, increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ready:
    - capture status 2'b10, read_data 0, `o_rsp_timeout=1`;
    - go to RESP and deassert `o_bus_valid` (abort).
- **RESP**
  - `o_rsp_valid=1`. Response fields are held stable.
  - On `i_rsp_ready`: go to IDLE.
- **Ignored inputs:**
  - `i_bus_ready` outside BUS, and the bus status/data fields outside the completion cycle.
  - `i_rsp_ready` outside RESP.
- **Counter width:** `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. It never wraps, since it is cleared on entry to BUS.
- **Simultaneous events:** ready in the same cycle as the timeout threshold counts as normal completion (ready wins, timeout=0).
- **Payload registers:** never updated outside the IDLE accept cycle.

## Timing
- **Reset values:** all outputs 0 except `o_cmd_ready=1`. Payload and response registers are reset to 0.
- **Command to bus:** command accepted at edge T, `o_bus_valid` high from cycle T+1 (registered, no combinational path cmd→bus).
- **Bus to response:** ready sampled high in cycle N gives `o_rsp_valid` in cycle N+1.
- **Back-to-back throughput:** one transaction per 3 cycles minimum.
- **Adapter handshake:** ready may be asserted in the first valid cycle. `o_bus_valid` stays high every cycle until ready or timeout, with no bubbles.
- **Timeout:** `o_bus_valid` is high for exactly TIMEOUT_CYCLES cycles when ready never arrives.
- **Response handshake:** response fields must not change while `o_rsp_valid=1 && !i_rsp_ready`.
- **Reset mid-operation:** returns to IDLE immediately, drops `o_bus_valid` and `o_rsp_valid`, and no response is produced.

## Test plan
- **Write:** access=`RGGEN_WRITE`, addr 0x10, data 0xDEADBEEF, strobe 4'hF; adapter ready 1 cycle later with status 00 -> bus payload matches; response status 00, read_data 0, timeout 0; o_busy low afterward.
- **Read with rsp backpressure:** access=`RGGEN_READ`, addr 0x24; ready on first valid cycle with data 0x12345678, status 2'b10; `i_rsp_ready` held low 4 cycles -> rsp_valid held, data 0x12345678, status 10 stable throughout.
- **Timeout:** TIMEOUT_CYCLES=8, ready never -> valid high exactly 8 cycles, then response status 10, data 0, timeout 1. Variant: ready on the 8th valid cycle -> normal completion, timeout 0.
- **Stalled bus, command hold-off:** ready delayed 20 cycles, TIMEOUT_CYCLES=0 -> no timeout; payload stable all 20 cycles; o_cmd_ready low and a second command is not accepted until after the response handshake.
- **Back-to-back:** 16 random commands with random ready/rsp_ready delays -> scoreboard checks one bus transaction per command in order, correct read data and status, no valid bubbles.
- **Reset during BUS and during RESP:** -> outputs return to reset values asynchronously; next command is processed normally.

Source files
------------

// File: rtl/rggen_bus_initiator_if.sv
// Signal bundle for rggen_bus_initiator: command port, rggen bus request and
// completion, and response port.
//   master : view of the initiator engine (drives o_* signals)
//   slave  : view of the host agent plus bus adapter (drives i_* signals)
interface rggen_bus_initiator_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int STROBE_WIDTH  = BUS_WIDTH / 8
);
    logic                     i_cmd_valid;
    logic                     o_cmd_ready;
    logic [1:0]               i_cmd_access;
    logic [ADDRESS_WIDTH-1:0] i_cmd_address;
    logic [BUS_WIDTH-1:0]     i_cmd_write_data;
    logic [STROBE_WIDTH-1:0]  i_cmd_strobe;

    logic                     o_bus_valid;
    logic [1:0]               o_bus_access;
    logic [ADDRESS_WIDTH-1:0] o_bus_address;
    logic [BUS_WIDTH-1:0]     o_bus_write_data;
    logic [STROBE_WIDTH-1:0]  o_bus_strobe;
    logic                     i_bus_ready;
    logic [1:0]               i_bus_status;
    logic [BUS_WIDTH-1:0]     i_bus_read_data;

    logic                     o_rsp_valid;
    logic                     i_rsp_ready;
    logic [1:0]               o_rsp_status;
    logic [BUS_WIDTH-1:0]     o_rsp_read_data;
    logic                     o_rsp_timeout;
    logic                     o_busy;

    modport master (
        input  i_cmd_valid, i_cmd_access, i_cmd_address, i_cmd_write_data, i_cmd_strobe,
        output o_cmd_ready,
        output o_bus_valid, o_bus_access, o_bus_address, o_bus_write_data, o_bus_strobe,
        input  i_bus_ready, i_bus_status, i_bus_read_data,
        output o_rsp_valid, o_rsp_status, o_rsp_read_data, o_rsp_timeout,
        input  i_rsp_ready,
        output o_busy
    );

    modport slave (
        output i_cmd_valid, i_cmd_access, i_cmd_address, i_cmd_write_data, i_cmd_strobe,
        input  o_cmd_ready,
        input  o_bus_valid, o_bus_access, o_bus_address, o_bus_write_data, o_bus_strobe,
        output i_bus_ready, i_bus_status, i_bus_read_data,
        input  o_rsp_valid, o_rsp_status, o_rsp_read_data, o_rsp_timeout,
        output i_rsp_ready,
        input  o_busy
    );
endinterface

// File: rtl/rggen_bus_initiator.sv
// Initiator engine for the rggen common register bus. Takes one command from
// the command port, issues it as exactly one bus transaction, and returns the
// completion (or a timeout abort) on the response port.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus_if  : rggen_bus_initiator_if.master (command, bus and response signals)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a command; payload registers load on accept
// BUS     | o_bus_valid high, waiting for adapter ready or timeout
// RESP    | o_rsp_valid high, holding the response until consumed
module rggen_bus_initiator #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int STROBE_WIDTH   = BUS_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    rggen_bus_initiator_if.master bus_if
);
    localparam logic [1:0] RGGEN_READ     = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int              CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]               state;
    logic [1:0]               state_next;

    logic [1:0]               pay_access;
    logic [ADDRESS_WIDTH-1:0] pay_address;
    logic [BUS_WIDTH-1:0]     pay_write_data;
    logic [STROBE_WIDTH-1:0]  pay_strobe;

    logic [1:0]               rsp_status;
    logic [BUS_WIDTH-1:0]     rsp_read_data;
    logic                     rsp_timeout;

    // Counts waiting cycles in BUS; index k means this is valid cycle k+1.
    logic [CNT_W-1:0]         timeout_cnt;
    logic                     timeout_hit;

    assign timeout_hit = TIMEOUT_EN && (timeout_cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus_if.i_cmd_valid) state_next = ST_BUS;
            // Ready in the threshold cycle still counts as a normal completion.
            ST_BUS:  if (bus_if.i_bus_ready || timeout_hit) state_next = ST_RESP;
            ST_RESP: if (bus_if.i_rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            pay_access     <= '0;
            pay_address    <= '0;
            pay_write_data <= '0;
            pay_strobe     <= '0;
            rsp_status     <= '0;
            rsp_read_data  <= '0;
            rsp_timeout    <= 1'b0;
            timeout_cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (bus_if.i_cmd_valid) begin
                        pay_access     <= bus_if.i_cmd_access;
                        pay_address    <= bus_if.i_cmd_address;
                        pay_write_data <= bus_if.i_cmd_write_data;
                        pay_strobe     <= bus_if.i_cmd_strobe;
                        timeout_cnt    <= '0;
                    end
                end
                ST_BUS: begin
                    if (bus_if.i_bus_ready) begin
                        rsp_status    <= bus_if.i_bus_status;
                        rsp_read_data <= (pay_access == RGGEN_READ) ? bus_if.i_bus_read_data : '0;
                        rsp_timeout   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_status    <= STATUS_TIMEOUT;
                        rsp_read_data <= '0;
                        rsp_timeout   <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_if.o_cmd_ready      = (state == ST_IDLE);
    assign bus_if.o_bus_valid      = (state == ST_BUS);
    assign bus_if.o_bus_access     = pay_access;
    assign bus_if.o_bus_address    = pay_address;
    assign bus_if.o_bus_write_data = pay_write_data;
    assign bus_if.o_bus_strobe     = pay_strobe;
    assign bus_if.o_rsp_valid      = (state == ST_RESP);
    assign bus_if.o_rsp_status     = rsp_status;
    assign bus_if.o_rsp_read_data  = rsp_read_data;
    assign bus_if.o_rsp_timeout    = rsp_timeout;
    assign bus_if.o_busy           = (state != ST_IDLE);
endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Bench for rggen_bus_initiator. Two instances share clock, reset and stimulus:
// dut0 has the timeout disabled, dut8 uses an 8-cycle timeout; sel picks which
// one receives commands and which one is observed.
module tb_rggen_bus_initiator;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int SW = 4;
    localparam int TO = 8;
    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel        = 1'b0;
    logic          cmd_valid  = 1'b0;
    logic [1:0]    cmd_access = '0;
    logic [AW-1:0] cmd_addr   = '0;
    logic [BW-1:0] cmd_wdata  = '0;
    logic [SW-1:0] cmd_strobe = '0;
    logic          bus_ready  = 1'b0;
    logic [1:0]    bus_status = '0;
    logic [BW-1:0] bus_rdata  = '0;
    logic          rsp_ready  = 1'b0;

    rggen_bus_initiator_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW)) if0 ();
    rggen_bus_initiator_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW)) if8 ();

    rggen_bus_initiator #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(0))
        dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus_if(if0.master));
    rggen_bus_initiator #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW), .TIMEOUT_CYCLES(TO))
        dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus_if(if8.master));

    assign if0.i_cmd_valid      = cmd_valid & ~sel;
    assign if8.i_cmd_valid      = cmd_valid & sel;
    assign if0.i_cmd_access     = cmd_access;
    assign if8.i_cmd_access     = cmd_access;
    assign if0.i_cmd_address    = cmd_addr;
    assign if8.i_cmd_address    = cmd_addr;
    assign if0.i_cmd_write_data = cmd_wdata;
    assign if8.i_cmd_write_data = cmd_wdata;
    assign if0.i_cmd_strobe     = cmd_strobe;
    assign if8.i_cmd_strobe     = cmd_strobe;
    assign if0.i_bus_ready      = bus_ready;
    assign if8.i_bus_ready      = bus_ready;
    assign if0.i_bus_status     = bus_status;
    assign if8.i_bus_status     = bus_status;
    assign if0.i_bus_read_data  = bus_rdata;
    assign if8.i_bus_read_data  = bus_rdata;
    assign if0.i_rsp_ready      = rsp_ready;
    assign if8.i_rsp_ready      = rsp_ready;

    logic          o_cmd_ready, o_bus_valid, o_rsp_valid, o_rsp_timeout, o_busy;
    logic [1:0]    o_bus_access, o_rsp_status;
    logic [AW-1:0] o_bus_addr;
    logic [BW-1:0] o_bus_wdata, o_rsp_rdata;
    logic [SW-1:0] o_bus_strobe;

    assign o_cmd_ready   = sel ? if8.o_cmd_ready      : if0.o_cmd_ready;
    assign o_bus_valid   = sel ? if8.o_bus_valid      : if0.o_bus_valid;
    assign o_bus_access  = sel ? if8.o_bus_access     : if0.o_bus_access;
    assign o_bus_addr    = sel ? if8.o_bus_address    : if0.o_bus_address;
    assign o_bus_wdata   = sel ? if8.o_bus_write_data : if0.o_bus_write_data;
    assign o_bus_strobe  = sel ? if8.o_bus_strobe     : if0.o_bus_strobe;
    assign o_rsp_valid   = sel ? if8.o_rsp_valid      : if0.o_rsp_valid;
    assign o_rsp_status  = sel ? if8.o_rsp_status     : if0.o_rsp_status;
    assign o_rsp_rdata   = sel ? if8.o_rsp_read_data  : if0.o_rsp_read_data;
    assign o_rsp_timeout = sel ? if8.o_rsp_timeout    : if0.o_rsp_timeout;
    assign o_busy        = sel ? if8.o_busy           : if0.o_busy;

    typedef struct {
        bit            sel;
        logic [1:0]    access;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strobe;
        int            rdy_dly;   // waiting cycles before ready; >= TO never seen on dut8
        logic [1:0]    status;
        logic [BW-1:0] rdata;
        int            rsp_dly;
        bit            hold;      // keep a second command offered while busy
        logic [1:0]    exp_status;
        logic [BW-1:0] exp_rdata;
        bit            exp_to;
    } vec_t;

    typedef struct {
        logic [1:0]    access;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strobe;
    } bus_exp_t;

    typedef struct {
        logic [1:0]    status;
        logic [BW-1:0] rdata;
        logic          to;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];
    bus_exp_t be;
    rsp_exp_t re;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within budget at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on each bus completion and each response handshake.
    always @(negedge clk) begin
        if (rst_n && o_bus_valid && bus_ready) begin
            if (bus_q.size() == 0) fail_now("bus_unexpected_txn");
            else begin
                be = bus_q.pop_front();
                chk("sb_bus_access", 64'(o_bus_access), 64'(be.access));
                chk("sb_bus_addr",   64'(o_bus_addr),   64'(be.addr));
                chk("sb_bus_wdata",  64'(o_bus_wdata),  64'(be.wdata));
                chk("sb_bus_strobe", 64'(o_bus_strobe), 64'(be.strobe));
            end
        end
        if (rst_n && o_rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) fail_now("rsp_unexpected");
            else begin
                re = rsp_q.pop_front();
                chk("sb_rsp_status",  64'(o_rsp_status),  64'(re.status));
                chk("sb_rsp_rdata",   64'(o_rsp_rdata),   64'(re.rdata));
                chk("sb_rsp_timeout", 64'(o_rsp_timeout), 64'(re.to));
            end
        end
    end

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.sel && v.rdy_dly >= TO) begin
            r.exp_status = 2'b10;
            r.exp_rdata  = '0;
            r.exp_to     = 1'b1;
        end else begin
            r.exp_status = v.status;
            r.exp_rdata  = (v.access == RD) ? v.rdata : '0;
            r.exp_to     = 1'b0;
        end
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
        chk({tag, "_bus_valid"}, 64'(o_bus_valid), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
        chk({tag, "_busy"},      64'(o_busy),      64'd0);
        chk({tag, "_bus_addr"},  64'(o_bus_addr),  64'd0);
        chk({tag, "_bus_wdata"}, 64'(o_bus_wdata), 64'd0);
        chk({tag, "_rsp_stat"},  64'(o_rsp_status), 64'd0);
        chk({tag, "_rsp_data"},  64'(o_rsp_rdata), 64'd0);
        chk({tag, "_rsp_to"},    64'(o_rsp_timeout), 64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        int cnt;
        bit done;
        int exp_cyc;
        bus_exp_t b;
        rsp_exp_t r;
        sel = v.sel;
        cnt = 0;
        #1;
        while (!o_cmd_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        if (!o_cmd_ready) fail_now("cmd_ready_wait");
        cmd_valid  = 1'b1;
        cmd_access = v.access;
        cmd_addr   = v.addr;
        cmd_wdata  = v.wdata;
        cmd_strobe = v.strobe;
        r.status = v.exp_status;
        r.rdata  = v.exp_rdata;
        r.to     = v.exp_to;
        rsp_q.push_back(r);
        if (!v.exp_to) begin
            b.access = v.access;
            b.addr   = v.addr;
            b.wdata  = v.wdata;
            b.strobe = v.strobe;
            bus_q.push_back(b);
        end
        tick();
        // Fresh values on the command port must never reach the payload.
        cmd_valid  = v.hold;
        cmd_access = 2'($urandom);
        cmd_addr   = AW'($urandom);
        cmd_wdata  = $urandom;
        cmd_strobe = SW'($urandom);

        cnt  = 0;
        done = 1'b0;
        repeat (200) if (!done) begin
            bus_ready  = (cnt == v.rdy_dly);
            bus_status = bus_ready ? v.status : 2'($urandom);
            bus_rdata  = bus_ready ? v.rdata : $urandom;
            @(negedge clk);
            if (!o_bus_valid) done = 1'b1;
            else begin
                cnt++;
                chk("bus_addr_hold",   64'(o_bus_addr),   64'(v.addr));
                chk("bus_wdata_hold",  64'(o_bus_wdata),  64'(v.wdata));
                chk("bus_access_hold", 64'(o_bus_access), 64'(v.access));
                chk("bus_strobe_hold", 64'(o_bus_strobe), 64'(v.strobe));
                chk("cmd_ready_in_bus", 64'(o_cmd_ready), 64'd0);
                if (bus_ready) done = 1'b1;
            end
            tick();
        end
        bus_ready = 1'b0;
        if (!done) fail_now("bus_phase_end");
        exp_cyc = v.exp_to ? TO : v.rdy_dly + 1;
        chk("bus_valid_cycles", 64'(cnt), 64'(exp_cyc));

        cnt  = 0;
        done = 1'b0;
        repeat (200) if (!done) begin
            rsp_ready = (cnt == v.rsp_dly);
            if (v.hold) cmd_valid = !rsp_ready;
            @(negedge clk);
            chk("rsp_valid",        64'(o_rsp_valid),   64'd1);
            chk("rsp_status_hold",  64'(o_rsp_status),  64'(v.exp_status));
            chk("rsp_rdata_hold",   64'(o_rsp_rdata),   64'(v.exp_rdata));
            chk("rsp_timeout_hold", 64'(o_rsp_timeout), 64'(v.exp_to));
            chk("cmd_ready_in_rsp", 64'(o_cmd_ready),   64'd0);
            if (!o_rsp_valid || rsp_ready) done = 1'b1;
            cnt++;
            tick();
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        if (!done) fail_now("rsp_phase_end");
        @(negedge clk);
        chk("busy_after", 64'(o_busy), 64'd0);
        chk("cmd_ready_after", 64'(o_cmd_ready), 64'd1);
    endtask

    vec_t dir_tab[6];
    vec_t v;

    initial begin
        dir_tab[0] = '{1'b0, WR, 8'h10, 32'hDEADBEEF, 4'hF, 1,   2'b00, 32'hA5A5A5A5, 0, 1'b0, 2'b00, 32'h0,        1'b0};
        dir_tab[1] = '{1'b0, RD, 8'h24, 32'h0,        4'h0, 0,   2'b10, 32'h12345678, 4, 1'b0, 2'b10, 32'h12345678, 1'b0};
        dir_tab[2] = '{1'b1, RD, 8'h30, 32'h11111111, 4'h3, 255, 2'b01, 32'hFFFF0000, 1, 1'b0, 2'b10, 32'h0,        1'b1};
        dir_tab[3] = '{1'b1, RD, 8'h31, 32'h0,        4'h0, 7,   2'b01, 32'hCAFEF00D, 0, 1'b0, 2'b01, 32'hCAFEF00D, 1'b0};
        dir_tab[4] = '{1'b0, WR, 8'h55, 32'h0BADF00D, 4'h5, 20,  2'b01, 32'h77777777, 2, 1'b1, 2'b01, 32'h0,        1'b0};
        dir_tab[5] = '{1'b1, WR, 8'hFF, 32'h01020304, 4'hC, 3,   2'b11, 32'h0,        0, 1'b0, 2'b11, 32'h0,        1'b0};

        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0;
        #1 check_reset_outputs("rst0");
        sel = 1'b1;
        #1 check_reset_outputs("rst8");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(dir_tab[i]);

        // Reset while dut0 is waiting in BUS.
        sel = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd_access = RD; cmd_addr = 8'h77; cmd_wdata = 32'h5555AAAA; cmd_strobe = 4'h9;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("pre_rst_bus_valid", 64'(o_bus_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_bus");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(dir_tab[0]);

        // Reset while dut8 is holding a response.
        sel = 1'b1;
        tick();
        cmd_valid = 1'b1; cmd_access = RD; cmd_addr = 8'h42; cmd_wdata = 32'h0; cmd_strobe = 4'h0;
        be.access = RD; be.addr = 8'h42; be.wdata = 32'h0; be.strobe = 4'h0;
        bus_q.push_back(be);
        tick();
        cmd_valid = 1'b0;
        bus_ready = 1'b1; bus_status = 2'b11; bus_rdata = 32'h89ABCDEF;
        tick();
        bus_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_rsp_valid", 64'(o_rsp_valid), 64'd1);
        chk("pre_rst_rsp_data",  64'(o_rsp_rdata), 64'h89ABCDEF);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_rsp");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(dir_tab[3]);

        for (int i = 0; i < 16; i++) begin
            v.sel     = 1'b0;
            v.access  = 2'($urandom_range(0, 3));
            v.addr    = AW'($urandom);
            v.wdata   = $urandom;
            v.strobe  = SW'($urandom);
            v.rdy_dly = $urandom_range(0, 4);
            v.status  = 2'($urandom);
            v.rdata   = $urandom;
            v.rsp_dly = $urandom_range(0, 3);
            v.hold    = 1'b0;
            run_txn(model(v));
        end
        for (int i = 0; i < 8; i++) begin
            v.sel     = 1'b1;
            v.access  = 2'($urandom_range(0, 1));
            v.addr    = AW'($urandom);
            v.wdata   = $urandom;
            v.strobe  = SW'($urandom);
            v.rdy_dly = $urandom_range(0, 10);
            v.status  = 2'($urandom);
            v.rdata   = $urandom;
            v.rsp_dly = $urandom_range(0, 2);
            v.hold    = 1'b0;
            run_txn(model(v));
        end

        chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
